cpu_sequencer: RTL and testbench

- Upstream neighbour of the instruction decoder in the DECA 4-bit-opcode CPU.
- Generates the one-hot FETCH/EXEC1/EXEC2 timing states and latches the instruction register from program memory.
- Supplies EQ/MI condition flags derived from the accumulator.
- Handles STP halting plus run/single-step control for board debugging.

---
 rtl/cpu_sequencer.sv | 118 +++++++++++
 tb/tb_cpu_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// FETCH/EXEC1/EXEC2 timing sequencer with instruction register, ACC flags and STP halt.
// Optional retired-instruction counter enabled by CPU_SEQUENCER_INSTR_COUNT_EN.
module cpu_sequencer #(
  parameter int IW  = 16,
  parameter int OPW = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              RUN,
  input  logic              STEP,
  input  logic [IW-1:0]     MEM_Q,
  input  logic              EXTRA,
  input  logic [IW-1:0]     ACC,
  output logic              FETCH,
  output logic              EXEC1,
  output logic              EXEC2,
  output logic [OPW-1:0]    IR_OP,
  output logic [IW-OPW-1:0] IR_OPND,
  output logic              EQ,
  output logic              MI,
`ifdef CPU_SEQUENCER_INSTR_COUNT_EN
  output logic [15:0]       INSTR_CNT,
`endif
  output logic              HALTED
);

  localparam logic [OPW-1:0] OP_STP = OPW'(7);

  typedef enum logic [1:0] {S_FETCH, S_EXEC1, S_EXEC2, S_HALT} state_t;

  state_t            state, state_next;
  logic              step_q;
  logic              adv;
  logic              ir_load;
  logic              retire;
  logic              halted;
  logic [OPW-1:0]    ir_op;
  logic [IW-OPW-1:0] ir_opnd;

  // Free-run, or exactly one advance per rising edge of the debounced STEP level.
  assign adv = RUN | (STEP & ~step_q);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= S_FETCH;
      step_q  <= 1'b0;
      halted  <= 1'b0;
      ir_op   <= '0;
      ir_opnd <= '0;
    end else begin
      state  <= state_next;
      step_q <= STEP;
      if (state_next == S_HALT) halted <= 1'b1;
      if (ir_load) begin
        ir_op   <= MEM_Q[IW-1 -: OPW];
        ir_opnd <= MEM_Q[IW-OPW-1:0];
      end
    end
  end

  always_comb begin
    state_next = state;
    ir_load    = 1'b0;
    retire     = 1'b0;
    case (state)
      S_FETCH: begin
        if (adv) begin
          state_next = S_EXEC1;
          ir_load    = 1'b1;
        end
      end
      S_EXEC1: begin
        if (adv) begin
          // STP wins over a concurrent EXTRA request from the decoder.
          if (ir_op == OP_STP) begin
            state_next = S_HALT;
          end else if (EXTRA) begin
            state_next = S_EXEC2;
          end else begin
            state_next = S_FETCH;
            retire     = 1'b1;
          end
        end
      end
      S_EXEC2: begin
        if (adv) begin
          state_next = S_FETCH;
          retire     = 1'b1;
        end
      end
      default: state_next = S_HALT;
    endcase
  end

`ifdef CPU_SEQUENCER_INSTR_COUNT_EN
  logic [15:0] instr_cnt;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)    instr_cnt <= 16'h0000;
    else if (retire) instr_cnt <= instr_cnt + 16'h0001;
  end

  assign INSTR_CNT = instr_cnt;
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

  assign FETCH   = (state == S_FETCH);
  assign EXEC1   = (state == S_EXEC1);
  assign EXEC2   = (state == S_EXEC2);
  assign HALTED  = halted;
  assign IR_OP   = ir_op;
  assign IR_OPND = ir_opnd;
  assign EQ      = (ACC == '0);
  assign MI      = ACC[IW-1];

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed scenarios plus randomized run against
// an instruction-position reference model.
module tb_cpu_sequencer;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        RUN = 1'b0;
  logic        STEP = 1'b0;
  logic [15:0] MEM_Q = 16'h0000;
  logic        EXTRA = 1'b0;
  logic [15:0] ACC = 16'h0000;
  logic        FETCH, EXEC1, EXEC2, EQ, MI, HALTED;
  logic [3:0]  IR_OP;
  logic [11:0] IR_OPND;
`ifdef CPU_SEQUENCER_INSTR_COUNT_EN
  logic [15:0] INSTR_CNT;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference model: position within the current instruction (0 fetch, 1 exec1, 2 exec2)
  int          m_pos;
  bit          m_halt;
  bit          m_step_q;
  logic [3:0]  m_op;
  logic [11:0] m_opnd;
  logic [15:0] m_cnt;

  cpu_sequencer #(.IW(16), .OPW(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .RUN(RUN), .STEP(STEP), .MEM_Q(MEM_Q),
    .EXTRA(EXTRA), .ACC(ACC), .FETCH(FETCH), .EXEC1(EXEC1), .EXEC2(EXEC2),
    .IR_OP(IR_OP), .IR_OPND(IR_OPND), .EQ(EQ), .MI(MI),
`ifdef CPU_SEQUENCER_INSTR_COUNT_EN
    .INSTR_CNT(INSTR_CNT),
`endif
    .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;

  function automatic logic [3:0] exp_st();
    if (m_halt)          return 4'b0001;
    else if (m_pos == 0) return 4'b1000;
    else if (m_pos == 1) return 4'b0100;
    else                 return 4'b0010;
  endfunction

  function automatic logic [3:0] dut_st();
    return {FETCH, EXEC1, EXEC2, HALTED};
  endfunction

  task automatic model_reset();
    m_pos = 0; m_halt = 0; m_step_q = 0; m_op = 4'h0; m_opnd = 12'h000; m_cnt = 16'h0000;
  endtask

  // One rising edge; model follows the instruction rules using the inputs present at the edge.
  task automatic clk_step();
    bit adv;
    @(posedge CLK);
    adv = RUN || (STEP && !m_step_q);
    m_step_q = STEP;
    if (!m_halt && adv) begin
      if (m_pos == 0) begin
        m_op = MEM_Q[15:12]; m_opnd = MEM_Q[11:0]; m_pos = 1;
      end else if (m_pos == 1) begin
        if (m_op == 4'h7) m_halt = 1;
        else if (EXTRA) m_pos = 2;
        else begin m_pos = 0; m_cnt = m_cnt + 16'h1; end
      end else begin
        m_pos = 0; m_cnt = m_cnt + 16'h1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    STEP = 1'b0; RUN = 1'b0;
    RESET_N = 1'b0;
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; #2;
    model_reset();
    vectors++;
    if (dut_st() !== 4'b1000 || IR_OP !== 4'h0 || IR_OPND !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_state: got st=%b ir=%h/%h, want st=1000 ir=0/000", dut_st(), IR_OP, IR_OPND);
    end
    @(posedge CLK); #1;
    RESET_N = 1'b1;
  endtask

  task automatic test_extra_instr();
    logic [3:0] exp [3] = '{4'b0100, 4'b0010, 4'b1000};
    do_reset();
    RUN = 1'b1; EXTRA = 1'b1; MEM_Q = 16'h2005;
    for (int i = 0; i < 3; i++) begin
      clk_step();
      vectors++;
      if (dut_st() !== exp[i] || IR_OP !== 4'h2 || IR_OPND !== 12'h005) begin
        miscompares++;
        $display("FAIL extra_seq[%0d]: got st=%b ir=%h/%h, want st=%b ir=2/005", i, dut_st(), IR_OP, IR_OPND, exp[i]);
      end
    end
  endtask

  task automatic test_short_instr();
    do_reset();
    RUN = 1'b1; EXTRA = 1'b0; MEM_Q = 16'h1010;
    for (int i = 0; i < 6; i++) begin
      clk_step();
      vectors++;
      if (dut_st() !== ((i % 2 == 0) ? 4'b0100 : 4'b1000) || IR_OP !== 4'h1 || IR_OPND !== 12'h010) begin
        miscompares++;
        $display("FAIL short_seq[%0d]: got st=%b ir=%h/%h, want st=%b ir=1/010", i, dut_st(), IR_OP, IR_OPND,
                 (i % 2 == 0) ? 4'b0100 : 4'b1000);
      end
    end
  endtask

  task automatic test_stp_halt();
    do_reset();
    RUN = 1'b1; EXTRA = 1'b1; MEM_Q = 16'h7000;
    clk_step();
    vectors++;
    if (dut_st() !== 4'b0100 || IR_OP !== 4'h7) begin
      miscompares++;
      $display("FAIL stp_exec1: got st=%b op=%h, want st=0100 op=7", dut_st(), IR_OP);
    end
    for (int i = 0; i < 21; i++) begin
      clk_step();
      RUN = 1'($urandom); STEP = 1'($urandom); EXTRA = 1'($urandom); MEM_Q = 16'($urandom);
      vectors++;
      if (dut_st() !== 4'b0001 || IR_OP !== 4'h7) begin
        miscompares++;
        $display("FAIL stp_halt[%0d]: got st=%b op=%h, want st=0001 op=7", i, dut_st(), IR_OP);
      end
    end
  endtask

  task automatic test_step();
    do_reset();
    RUN = 1'b0; EXTRA = 1'b0; MEM_Q = 16'h1010; STEP = 1'b1;
    for (int i = 0; i < 5; i++) begin
      clk_step();
      vectors++;
      if (dut_st() !== 4'b0100) begin
        miscompares++;
        $display("FAIL step_hold[%0d]: got st=%b, want 0100", i, dut_st());
      end
    end
    STEP = 1'b0;
    clk_step();
    vectors++;
    if (dut_st() !== 4'b0100) begin
      miscompares++;
      $display("FAIL step_low: got st=%b, want 0100", dut_st());
    end
    STEP = 1'b1;
    clk_step();
    vectors++;
    if (dut_st() !== 4'b1000) begin
      miscompares++;
      $display("FAIL step_second: got st=%b, want 1000", dut_st());
    end
    STEP = 1'b0;
    clk_step();
    RUN = 1'b1; STEP = 1'b1;
    clk_step();
    vectors++;
    if (dut_st() !== 4'b0100) begin
      miscompares++;
      $display("FAIL run_and_step: got st=%b, want 0100", dut_st());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    RUN = 1'b1; EXTRA = 1'b1; MEM_Q = 16'h3123;
    clk_step();
    clk_step();
    vectors++;
    if (dut_st() !== 4'b0010 || IR_OP !== 4'h3 || IR_OPND !== 12'h123) begin
      miscompares++;
      $display("FAIL pre_reset_exec2: got st=%b ir=%h/%h, want st=0010 ir=3/123", dut_st(), IR_OP, IR_OPND);
    end
    #2 RESET_N = 1'b0;
    #1;
    vectors++;
    if (dut_st() !== 4'b1000 || IR_OP !== 4'h0 || IR_OPND !== 12'h000) begin
      miscompares++;
      $display("FAIL async_reset: got st=%b ir=%h/%h, want st=1000 ir=0/000", dut_st(), IR_OP, IR_OPND);
    end
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    model_reset();
  endtask

  task automatic test_flags();
    logic [15:0] acc_v [4] = '{16'h0000, 16'h8001, 16'h7FFF, 16'hFFFF};
    for (int i = 0; i < 12; i++) begin
      ACC = (i < 4) ? acc_v[i] : 16'($urandom);
      #1;
      vectors++;
      if (EQ !== (ACC == 16'h0) || MI !== (ACC >= 16'h8000)) begin
        miscompares++;
        $display("FAIL flags acc=%h: got eq=%b mi=%b, want eq=%b mi=%b", ACC, EQ, MI, ACC == 16'h0, ACC >= 16'h8000);
      end
    end
  endtask

  task automatic test_random();
    int halt_cycles = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      RUN   = ($urandom_range(0, 3) != 0);
      STEP  = 1'($urandom);
      EXTRA = 1'($urandom);
      MEM_Q = 16'($urandom);
      if (MEM_Q[15:12] == 4'h7 && $urandom_range(0, 3) != 0) MEM_Q[15:12] = 4'h5;
      clk_step();
      vectors++;
      if (dut_st() !== exp_st() || {IR_OP, IR_OPND} !== {m_op, m_opnd}) begin
        miscompares++;
        $display("FAIL random[%0d]: got st=%b ir=%h%h, want st=%b ir=%h%h", i, dut_st(), IR_OP, IR_OPND,
                 exp_st(), m_op, m_opnd);
      end
`ifdef CPU_SEQUENCER_INSTR_COUNT_EN
      vectors++;
      if (INSTR_CNT !== m_cnt) begin
        miscompares++;
        $display("FAIL random_cnt[%0d]: got %0d, want %0d", i, INSTR_CNT, m_cnt);
      end
`endif
      if (m_halt) halt_cycles++;
      if (halt_cycles > 4) begin
        halt_cycles = 0;
        do_reset();
      end
    end
  endtask

`ifdef CPU_SEQUENCER_INSTR_COUNT_EN
  task automatic test_instr_count();
    do_reset();
    RUN = 1'b1; EXTRA = 1'b0; MEM_Q = 16'h1010;
    for (int i = 0; i < 6; i++) clk_step();
    vectors++;
    if (INSTR_CNT !== 16'd3) begin
      miscompares++;
      $display("FAIL count_three: got %0d, want 3", INSTR_CNT);
    end
    dut.instr_cnt = 16'hFFFE;
    for (int i = 0; i < 4; i++) clk_step();
    vectors++;
    if (INSTR_CNT !== 16'h0000) begin
      miscompares++;
      $display("FAIL count_wrap: got %h, want 0000", INSTR_CNT);
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_extra_instr();
    test_short_instr();
    test_stp_halt();
    test_step();
    test_reset_mid();
    test_flags();
    test_random();
`ifdef CPU_SEQUENCER_INSTR_COUNT_EN
    test_instr_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
